// File: rtl/uc_ctrl_pkg.sv
// Shared types for the multicycle controller: FSM states, opcodes, ALU/WB selects, trap causes, decode helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package uc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPCODE_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_BEQ = 3'b000;
  localparam logic [2:0] FUNCT3_BNE = 3'b001;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic {
    TRAP_ILLEGAL = 1'b0,
    TRAP_BUS     = 1'b1
  } trap_cause_e;

  // Instruction class captured in DECODE so later states do not depend on the IR inputs.
  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5
  } instr_cls_e;

  typedef struct packed {
    logic       legal;
    instr_cls_e cls;
  } decode_t;

  function automatic decode_t decode_instr(input logic [6:0] op, input logic [2:0] f3);
    decode_t d;
    d.legal = 1'b1;
    d.cls   = CLS_R;
    case (op)
      OPCODE_R_TYPE: d.cls = CLS_R;
      OPCODE_I_TYPE: d.cls = CLS_I;
      OPCODE_LOAD:   d.cls = CLS_LOAD;
      OPCODE_STORE:  d.cls = CLS_STORE;
      OPCODE_BRANCH: begin
        d.cls   = CLS_BRANCH;
        // only beq/bne are implemented
        d.legal = (f3 == FUNCT3_BEQ) || (f3 == FUNCT3_BNE);
      end
      OPCODE_JAL:    d.cls = CLS_JAL;
      default:       d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uc_mem_timeout.sv
// Memory-wait watchdog: counts cycles req is high without ack; flags expiry on the TIMEOUT_CYCLES-th such cycle.
// Latency: expired is combinational in the cycle the limit is reached; an ack in that cycle suppresses it.
// Backpressure: none; ports clk, arst (async active-high), req, ack in; expired out.
module uc_mem_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic arst,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] cnt;

  // Clearing whenever req is low also covers state exits: every exit either acks or drops req.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (!req || ack) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  // cnt holds the number of earlier waiting cycles, so the current one is number cnt+1.
  assign expired = req && !ack && (cnt == TMO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uc_multicycle_ctrl.sv
// Multicycle control FSM for the uC datapath; owns the shared instr/data memory req/ack handshake.
// Latency: with same-cycle ack, branch 3, R/I/store/jal 4, load 5 cycles; trap state is terminal until arst.
// Backpressure: mem_req/mem_we/mem_addr_sel held until mem_ack; TIMEOUT_CYCLES unacked cycles trap (bus).
// Ports: clk, arst; opcode/funct3 from IR, alu_zero, mem_ack in; memory, datapath enables/selects, trap out.
// Optional UC_CTRL_PERF_EN adds cycle_cnt and instret counter outputs.
module uc_multicycle_ctrl
  import uc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       memread,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       memtoreg,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       trap,
  output logic       trap_cause
`ifdef UC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
`endif
);

  state_e      state, state_nxt;
  instr_cls_e  cls_q;
  logic        bne_q;
  logic        run_q;
  trap_cause_e cause_q, cause_nxt;
  decode_t     dec;
  logic        req_int;
  logic        tmo_expired;
  alu_op_e     alu_op_int;
  wb_sel_e     wb_sel_int;

  assign dec = decode_instr(opcode, funct3);

  // run_q keeps FETCH quiet for the first cycle after reset, so an ack left over
  // from an aborted transaction meets mem_req=0 and is ignored.
  assign req_int = ((state == ST_FETCH) && run_q) || (state == ST_MEM);

  uc_mem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .arst    (arst),
    .req     (req_int),
    .ack     (mem_ack),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= ST_FETCH;
      cls_q   <= CLS_R;
      bne_q   <= 1'b0;
      run_q   <= 1'b0;
      cause_q <= TRAP_ILLEGAL;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
      if (state == ST_DECODE) begin
        cls_q <= dec.cls;
        bne_q <= (funct3 == FUNCT3_BNE);
      end
      if ((state != ST_TRAP) && (state_nxt == ST_TRAP)) begin
        cause_q <= cause_nxt;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cause_nxt    = TRAP_ILLEGAL;
    mem_req      = req_int;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    memread      = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    rf_we        = 1'b0;
    wb_sel_int   = WB_ALU;
    alu_src_b    = 1'b0;
    alu_op_int   = ALU_ADD;

    case (state)
      ST_FETCH: begin
        if (req_int && mem_ack) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = ST_DECODE;
        end else if (tmo_expired) begin
          cause_nxt = TRAP_BUS;
          state_nxt = ST_TRAP;
        end
      end

      ST_DECODE: begin
        if (dec.legal) begin
          state_nxt = ST_EXEC;
        end else begin
          cause_nxt = TRAP_ILLEGAL;
          state_nxt = ST_TRAP;
        end
      end

      ST_EXEC: begin
        case (cls_q)
          CLS_R: begin
            alu_op_int = ALU_FUNCT;
            state_nxt  = ST_WB;
          end
          CLS_I: begin
            alu_op_int = ALU_FUNCT;
            alu_src_b  = 1'b1;
            state_nxt  = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_b = 1'b1;
            state_nxt = ST_MEM;
          end
          CLS_BRANCH: begin
            alu_op_int = ALU_SUB;
            pc_sel     = 1'b1;
            pc_we      = bne_q ? !alu_zero : alu_zero;
            state_nxt  = ST_FETCH;
          end
          CLS_JAL: begin
            pc_we     = 1'b1;
            pc_sel    = 1'b1;
            state_nxt = ST_WB;
          end
          default: begin
            cause_nxt = TRAP_ILLEGAL;
            state_nxt = ST_TRAP;
          end
        endcase
      end

      ST_MEM: begin
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == CLS_STORE);
        memread      = (cls_q == CLS_LOAD);
        // keep the address computation alive while the access is outstanding
        alu_src_b    = 1'b1;
        if (mem_ack) begin
          state_nxt = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
        end else if (tmo_expired) begin
          cause_nxt = TRAP_BUS;
          state_nxt = ST_TRAP;
        end
      end

      ST_WB: begin
        rf_we     = 1'b1;
        state_nxt = ST_FETCH;
        case (cls_q)
          CLS_LOAD: wb_sel_int = WB_MEM;
          CLS_JAL:  wb_sel_int = WB_PC4;
          default: begin
            // R/I write the ALU result, so the ALU controls stay as in EXEC
            wb_sel_int = WB_ALU;
            alu_op_int = ALU_FUNCT;
            alu_src_b  = (cls_q == CLS_I);
          end
        endcase
      end

      ST_TRAP: begin
        state_nxt = ST_TRAP;
      end

      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  assign wb_sel     = wb_sel_int;
  assign alu_op     = alu_op_int;
  assign memtoreg   = (wb_sel_int == WB_MEM);
  assign trap       = (state == ST_TRAP);
  assign trap_cause = cause_q;

`ifdef UC_CTRL_PERF_EN
  // An instruction retires on any transition back into FETCH.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if (state != ST_TRAP) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if ((state != ST_FETCH) && (state_nxt == ST_FETCH)) begin
        instret <= instret + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uc_multicycle_ctrl.sv
// Self-checking bench for uc_multicycle_ctrl: per-cycle expected control vectors are queued per instruction
// and popped/compared each cycle; covers reset, all instruction classes, delayed ack, traps and timeout.
// Runs with TIMEOUT_CYCLES=4; UC_CTRL_PERF_EN additionally checks cycle_cnt/instret.
module tb_uc_multicycle_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, memread, ir_we, pc_we, pc_sel, rf_we;
  logic [1:0] wb_sel, alu_op;
  logic       memtoreg, alu_src_b, trap, trap_cause;
`ifdef UC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret;
  int          cyc_m, inst_m;
`endif

  uc_multicycle_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .arst         (arst),
    .opcode       (opcode),
    .funct3       (funct3),
    .alu_zero     (alu_zero),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .memread      (memread),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .memtoreg     (memtoreg),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .trap         (trap),
    .trap_cause   (trap_cause)
`ifdef UC_CTRL_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret      (instret)
`endif
  );

  always #5 clk = ~clk;

  // Observed control vector, one bit/field per output.
  logic [15:0] obs;
  assign obs = {mem_req, mem_we, mem_addr_sel, memread, ir_we, pc_we, pc_sel, rf_we,
                wb_sel, memtoreg, alu_src_b, alu_op, trap, trap_cause};

  localparam logic [15:0] V_REQ   = 16'h8000;
  localparam logic [15:0] V_WE    = 16'h4000;
  localparam logic [15:0] V_ASEL  = 16'h2000;
  localparam logic [15:0] V_MRD   = 16'h1000;
  localparam logic [15:0] V_IRWE  = 16'h0800;
  localparam logic [15:0] V_PCWE  = 16'h0400;
  localparam logic [15:0] V_PCSEL = 16'h0200;
  localparam logic [15:0] V_RFWE  = 16'h0100;
  localparam logic [15:0] V_SRCB  = 16'h0010;
  localparam logic [15:0] V_TRAP  = 16'h0002;
  localparam logic [15:0] V_CAUSE = 16'h0001;

  // Fields whose value only matters in some states are masked elsewhere.
  localparam logic [15:0] B_PCSEL = 16'h0200;
  localparam logic [15:0] B_WB    = 16'h00E0;
  localparam logic [15:0] B_ALU   = 16'h001C;
  localparam logic [15:0] M_BASE  = 16'hFD03;
  localparam logic [15:0] M_ALL   = 16'hFFFF;

  function automatic logic [15:0] wbv(input int s);
    logic [15:0] v;
    v = 16'(s) << 6;
    if (s == 1) v = v | 16'h0020;
    return v;
  endfunction

  function automatic logic [15:0] aop(input int n);
    return 16'(n) << 2;
  endfunction

  typedef struct {
    logic        ack;
    logic [15:0] exp;
    logic [15:0] mask;
    logic        retire;
    string       tag;
  } step_t;

  step_t sbq[$];
  string cur = "none";
  int    n_chk = 0;
  int    n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  task automatic push(input logic ack, input logic [15:0] exp, input logic [15:0] mask,
                      input logic retire, input string st);
    step_t s;
    s.ack = ack; s.exp = exp; s.mask = mask; s.retire = retire;
    s.tag = {cur, "_", st};
    sbq.push_back(s);
  endtask

  task automatic step(input step_t s);
    @(negedge clk);
    mem_ack = s.ack;
    #1;
`ifdef UC_CTRL_PERF_EN
    check_eq({s.tag, "_cyc"}, cycle_cnt, cyc_m);
    check_eq({s.tag, "_inst"}, instret, inst_m);
    if (!s.exp[1]) cyc_m++;
    if (s.retire) inst_m++;
`endif
    check_eq(s.tag, {16'h0, obs & s.mask}, {16'h0, s.exp & s.mask});
  endtask

  task automatic run_q();
    step_t s;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      step(s);
    end
  endtask

  task automatic set_instr(input string name, input logic [31:0] ins, input logic az);
    cur      = name;
    opcode   = ins[6:0];
    funct3   = ins[14:12];
    alu_zero = az;
  endtask

  task automatic p_fetch();
    push(1'b1, V_REQ | V_IRWE | V_PCWE, M_BASE | B_PCSEL, 1'b0, "fetch");
  endtask

  task automatic p_dec(input logic ack);
    push(ack, 16'h0000, M_BASE, 1'b0, "decode");
  endtask

  // Holds reset across a clock edge, then releases it with a stale ack present.
  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1;
    mem_ack = 1'b1;
    #1;
    check_eq({cur, "_in_rst"}, {16'h0, obs}, 32'h0);
    @(negedge clk);
    arst = 1'b0;
    #1;
    check_eq({cur, "_post_rst_ack_ignored"}, {16'h0, obs}, 32'h0);
`ifdef UC_CTRL_PERF_EN
    check_eq({cur, "_rst_cyc"}, cycle_cnt, 32'd0);
    check_eq({cur, "_rst_inst"}, instret, 32'd0);
    cyc_m  = 1;
    inst_m = 0;
`endif
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        az;
    logic        taken;
    string       name;
  } br_t;

  initial begin
    br_t br[4];
    br[0] = '{32'h00000463, 1'b1, 1'b1, "beq_z1"};
    br[1] = '{32'h00001463, 1'b1, 1'b0, "bne_z1"};
    br[2] = '{32'h00000463, 1'b0, 1'b0, "beq_z0"};
    br[3] = '{32'h00001463, 1'b0, 1'b1, "bne_z0"};

    cur = "init";
    do_reset();

    // addi x1,x2,5
    set_instr("addi", 32'h00510093, 1'b0);
    p_fetch(); p_dec(1'b0);
    push(1'b0, V_SRCB | aop(2), M_BASE | B_ALU, 1'b0, "exec");
    push(1'b0, V_RFWE | wbv(0), M_BASE | B_WB, 1'b1, "wb");
    run_q();

    // lw x1,0(x2) with ack held off 3 cycles (ack lands on the timeout-limit cycle)
    set_instr("lw", 32'h00012083, 1'b0);
    p_fetch(); p_dec(1'b1);
    push(1'b0, V_SRCB | aop(0), M_BASE | B_ALU, 1'b0, "exec");
    for (int i = 0; i < 3; i++) push(1'b0, V_REQ | V_ASEL | V_MRD, M_BASE, 1'b0, "mem_wait");
    push(1'b1, V_REQ | V_ASEL | V_MRD, M_BASE, 1'b0, "mem_ack");
    push(1'b0, V_RFWE | wbv(1), M_BASE | B_WB, 1'b1, "wb");
    run_q();

    // sw x1,0(x2)
    set_instr("sw", 32'h00112023, 1'b0);
    p_fetch(); p_dec(1'b0);
    push(1'b0, V_SRCB | aop(0), M_BASE | B_ALU, 1'b0, "exec");
    push(1'b1, V_REQ | V_WE | V_ASEL, M_BASE, 1'b1, "mem");
    run_q();

    foreach (br[i]) begin
      set_instr(br[i].name, br[i].ins, br[i].az);
      p_fetch(); p_dec(1'b0);
      push(1'b0, (br[i].taken ? V_PCWE : 16'h0) | V_PCSEL | aop(1),
           M_BASE | B_ALU | B_PCSEL, 1'b1, "exec");
      run_q();
    end

    // add x3,x1,x2; ack during WB must be ignored
    set_instr("add", 32'h002081B3, 1'b0);
    p_fetch(); p_dec(1'b0);
    push(1'b0, aop(2), M_BASE | B_ALU, 1'b0, "exec");
    push(1'b1, V_RFWE | wbv(0), M_BASE | B_WB, 1'b1, "wb");
    run_q();

    // jal x1,16
    set_instr("jal", 32'h010000EF, 1'b0);
    p_fetch(); p_dec(1'b0);
    push(1'b0, V_PCWE | V_PCSEL, M_BASE | B_PCSEL, 1'b0, "exec");
    push(1'b0, V_RFWE | wbv(2), M_BASE | B_WB, 1'b1, "wb");
    run_q();

    // sw aborted by arst while waiting in MEM
    set_instr("sw_rst", 32'h00112023, 1'b0);
    p_fetch(); p_dec(1'b0);
    push(1'b0, V_SRCB | aop(0), M_BASE | B_ALU, 1'b0, "exec");
    push(1'b0, V_REQ | V_WE | V_ASEL, M_BASE, 1'b0, "mem_wait");
    run_q();
    arst = 1'b1;
    #1;
    check_eq("sw_rst_async_drop", {16'h0, obs}, 32'h0);
`ifdef UC_CTRL_PERF_EN
    check_eq("sw_rst_async_inst", instret, 32'd0);
    check_eq("sw_rst_async_cyc", cycle_cnt, 32'd0);
`endif
    do_reset();
    set_instr("addi_after_rst", 32'h00510093, 1'b0);
    p_fetch(); p_dec(1'b0);
    push(1'b0, V_SRCB | aop(2), M_BASE | B_ALU, 1'b0, "exec");
    push(1'b0, V_RFWE | wbv(0), M_BASE | B_WB, 1'b1, "wb");
    run_q();

    // illegal opcode 0x7F: terminal trap, no request even with ack toggling
    set_instr("illegal", 32'h0000007F, 1'b0);
    p_fetch(); p_dec(1'b0);
    for (int i = 0; i < 20; i++) push(1'(i % 2), V_TRAP, M_ALL, 1'b0, "trap");
    run_q();
    do_reset();

    // branch with unsupported funct3
    set_instr("br_f3_2", 32'h00002463, 1'b0);
    p_fetch(); p_dec(1'b0);
    for (int i = 0; i < 3; i++) push(1'b0, V_TRAP, M_ALL, 1'b0, "trap");
    run_q();
    do_reset();

    // fetch never acknowledged: req for TMO cycles, then bus trap
    set_instr("fetch_tmo", 32'h00510093, 1'b0);
    for (int i = 0; i < TMO; i++) push(1'b0, V_REQ, M_BASE, 1'b0, "fetch_wait");
    for (int i = 0; i < 4; i++) push(1'(i % 2), V_TRAP | V_CAUSE, M_ALL, 1'b0, "trap");
    run_q();
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
